chdr_framer: RTL and testbench

- Store-and-forward packetizer that sits directly downstream of the axi_wrapper user-logic output path, i.e. the stage that rebuilds CHDR from processed samples.
- Accepts 32-bit samples with a 128-bit tuser header/time sideband, packs them into 64-bit words, counts payload and generates the CHDR header (length, sequence number).
- Emits complete CHDR packets on a 64-bit AXI-stream toward the crossbar/noc_shell.

---
 rtl/chdr_pkg.sv | 34 +++
 rtl/chdr_framer_fifo.sv | 50 +++++
 rtl/chdr_framer.sv | 183 ++++++++++++++++++
 tb/tb_chdr_framer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/chdr_pkg.sv
// rtl/chdr_pkg.sv - CHDR header field offsets, header-FIFO entry layout and framer FSM states
package chdr_pkg;

    localparam int PKT_TYPE_OFF = 62;
    localparam int HAS_TIME_OFF = 61;
    localparam int EOB_OFF      = 60;
    localparam int SEQNUM_OFF   = 48;
    localparam int LEN_OFF      = 32;
    localparam int SID_OFF      = 0;

    localparam int SEQNUM_W = 12;
    localparam int LEN_W    = 16;
    localparam int NWORDS_W = 16;

    typedef struct packed {
        logic [63:0]         hdr;
        logic [63:0]         time_w;
        logic [NWORDS_W-1:0] nwords;
    } hdr_entry_t;

    localparam int HDR_ENTRY_W = $bits(hdr_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_TIME,
        ST_BODY
    } state_t;

    function automatic logic [LEN_W-1:0] chdr_len(input logic [15:0] nsamps, input logic has_time);
        return (nsamps << 2) + 16'd8 + (has_time ? 16'd8 : 16'd0);
    endfunction

endpackage

// File: rtl/chdr_framer_fifo.sv
// rtl/chdr_framer_fifo.sv - first-word-fall-through stream FIFO, async active-low reset, sync clear
module chdr_framer_fifo #(
    parameter int WIDTH = 64,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready
);
    localparam int DEPTH = 1 << SIZE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE-1:0]  wptr, rptr;
    logic [SIZE:0]    count;
    logic             push, pop;

    // A full FIFO still accepts a write in the same cycle its head is read.
    assign i_tready = ~count[SIZE] | o_tready;
    assign o_tvalid = (count != '0);
    assign o_tdata  = mem[rptr];
    assign push     = i_tvalid & i_tready;
    assign pop      = o_tvalid & o_tready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (SIZE+1)'(push) - (SIZE+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= i_tdata;
    end

endmodule

// File: rtl/chdr_framer.sv
// rtl/chdr_framer.sv - store-and-forward packer of 32-bit samples into CHDR packets on a 64-bit stream
module chdr_framer
    import chdr_pkg::*;
#(
    parameter int SIZE          = 10,
    parameter int HDR_SIZE      = 4,
    parameter int MAX_PKT_SAMPS = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [31:0]  i_tdata,
    input  logic [127:0] i_tuser,
    input  logic         i_tlast,
    input  logic         i_tvalid,
    output logic         i_tready,
    output logic [63:0]  o_tdata,
    output logic         o_tlast,
    output logic         o_tvalid,
    input  logic         o_tready
);
    logic         pay_in_rdy, hdr_in_rdy, pay_valid, hdr_valid, pay_pop, hdr_pop;
    logic [63:0]  pay_word, pay_out;
    hdr_entry_t   hdr_in, hdr_out;

    logic         in_pkt;
    logic [127:0] tuser_q, tuser_cur;
    logic [15:0]  nsamps, cnt;
    logic [31:0]  even_q;
    logic [11:0]  seqnum;
    logic         accept, close, odd;

    assign i_tready  = reset & pay_in_rdy & hdr_in_rdy;
    assign accept    = i_tvalid & i_tready;
    assign tuser_cur = in_pkt ? tuser_q : i_tuser;
    assign cnt       = nsamps + 16'd1;
    assign close     = i_tlast | (cnt == 16'(MAX_PKT_SAMPS));
    assign odd       = nsamps[0];
    assign pay_word  = odd ? {even_q, i_tdata} : {i_tdata, 32'h0};

    // Sequence number is always ours; eob only survives on the segment that carries tlast.
    always_comb begin
        hdr_in.hdr                         = tuser_cur[127:64];
        hdr_in.hdr[EOB_OFF]                = tuser_cur[64+EOB_OFF] & i_tlast;
        hdr_in.hdr[SEQNUM_OFF +: SEQNUM_W] = seqnum;
        hdr_in.hdr[LEN_OFF +: LEN_W]       = chdr_len(cnt, tuser_cur[64+HAS_TIME_OFF]);
        hdr_in.time_w                      = tuser_cur[63:0];
        hdr_in.nwords                      = (cnt + 16'd1) >> 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_pkt  <= 1'b0;
            tuser_q <= '0;
            nsamps  <= '0;
            even_q  <= '0;
            seqnum  <= '0;
        end else if (clear) begin
            in_pkt  <= 1'b0;
            tuser_q <= '0;
            nsamps  <= '0;
            even_q  <= '0;
            seqnum  <= '0;
        end else if (accept) begin
            if (!in_pkt) tuser_q <= i_tuser;
            if (!odd)    even_q  <= i_tdata;
            if (close) begin
                nsamps <= '0;
                in_pkt <= ~i_tlast;  // forced split keeps the captured tuser
                seqnum <= seqnum + 12'd1;
            end else begin
                nsamps <= cnt;
                in_pkt <= 1'b1;
            end
        end
    end

    chdr_framer_fifo #(.WIDTH(64), .SIZE(SIZE)) u_pay_fifo (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(pay_word), .i_tvalid(accept & (odd | close)), .i_tready(pay_in_rdy),
        .o_tdata(pay_out), .o_tvalid(pay_valid), .o_tready(pay_pop)
    );

    chdr_framer_fifo #(.WIDTH(HDR_ENTRY_W), .SIZE(HDR_SIZE)) u_hdr_fifo (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(hdr_in), .i_tvalid(accept & close), .i_tready(hdr_in_rdy),
        .o_tdata(hdr_out), .o_tvalid(hdr_valid), .o_tready(hdr_pop)
    );

    state_t      state, state_n;
    logic [63:0] tdata_n, cur_time, time_n;
    logic        tlast_n, cur_has_time, ht_n, load_hdr, load_body;
    logic [15:0] words_left, left_n;

    assign o_tvalid = (state != ST_IDLE);

    // The header entry is consumed when HEAD is loaded, so the next packet's
    // header can follow the last body word without an idle cycle.
    always_comb begin
        state_n   = state;
        tdata_n   = o_tdata;
        tlast_n   = o_tlast;
        time_n    = cur_time;
        ht_n      = cur_has_time;
        left_n    = words_left;
        hdr_pop   = 1'b0;
        pay_pop   = 1'b0;
        load_hdr  = 1'b0;
        load_body = 1'b0;
        case (state)
            ST_IDLE: load_hdr = hdr_valid;
            ST_HEAD: begin
                if (o_tready) begin
                    if (cur_has_time) begin
                        tdata_n = cur_time;
                        tlast_n = 1'b0;
                        state_n = ST_TIME;
                    end else begin
                        load_body = pay_valid;
                    end
                end
            end
            ST_TIME: load_body = o_tready & pay_valid;
            ST_BODY: begin
                if (o_tready) begin
                    if (words_left == 16'd0) begin
                        if (hdr_valid) begin
                            load_hdr = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            tlast_n = 1'b0;
                        end
                    end else begin
                        load_body = pay_valid;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (load_hdr) begin
            hdr_pop = 1'b1;
            tdata_n = hdr_out.hdr;
            tlast_n = 1'b0;
            time_n  = hdr_out.time_w;
            ht_n    = hdr_out.hdr[HAS_TIME_OFF];
            left_n  = hdr_out.nwords;
            state_n = ST_HEAD;
        end
        if (load_body) begin
            pay_pop = 1'b1;
            tdata_n = pay_out;
            left_n  = words_left - 16'd1;
            tlast_n = (words_left == 16'd1);
            state_n = ST_BODY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            o_tdata      <= '0;
            o_tlast      <= 1'b0;
            cur_time     <= '0;
            cur_has_time <= 1'b0;
            words_left   <= '0;
        end else if (clear) begin
            state        <= ST_IDLE;
            o_tdata      <= '0;
            o_tlast      <= 1'b0;
            cur_time     <= '0;
            cur_has_time <= 1'b0;
            words_left   <= '0;
        end else begin
            state        <= state_n;
            o_tdata      <= tdata_n;
            o_tlast      <= tlast_n;
            cur_time     <= time_n;
            cur_has_time <= ht_n;
            words_left   <= left_n;
        end
    end

endmodule

// File: tb/tb_chdr_framer.sv
// tb/tb_chdr_framer.sv - scoreboard bench for chdr_framer (default and MAX_PKT_SAMPS=8 instances)
module tb_chdr_framer;

    logic         clk = 1'b0;
    logic         reset, clear, sel;
    logic [31:0]  i_tdata;
    logic [127:0] i_tuser;
    logic         i_tlast, i_tvalid, o_tready, tog_en, rdy_level;
    logic         val_a, val_b, rdy_a, rdy_b, ol_a, ol_b, ov_a, ov_b;
    logic [63:0]  od_a, od_b;

    int total = 0;
    int bad   = 0;
    logic [64:0] q_a[$];
    logic [64:0] q_b[$];
    logic [11:0] seq_a, seq_b;

    always #5 clk = ~clk;

    assign val_a = i_tvalid & ~sel;
    assign val_b = i_tvalid & sel;

    chdr_framer dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(val_a), .i_tready(rdy_a),
        .o_tdata(od_a), .o_tlast(ol_a), .o_tvalid(ov_a), .o_tready(o_tready)
    );

    chdr_framer #(.SIZE(4), .HDR_SIZE(2), .MAX_PKT_SAMPS(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(val_b), .i_tready(rdy_b),
        .o_tdata(od_b), .o_tlast(ol_b), .o_tvalid(ov_b), .o_tready(o_tready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        o_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (tog_en) o_tready = ~o_tready;
            else        o_tready = rdy_level;
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (ov_a && o_tready) begin
            if (q_a.size() == 0) chk("a_unexpected_word", 64'(ov_a), 64'd0);
            else begin
                logic [64:0] e;
                e = q_a.pop_front();
                chk("a_data", od_a, e[63:0]);
                chk("a_tlast", 64'(ol_a), 64'(e[64]));
            end
        end
        if (ov_b && o_tready) begin
            if (q_b.size() == 0) chk("b_unexpected_word", 64'(ov_b), 64'd0);
            else begin
                logic [64:0] e;
                e = q_b.pop_front();
                chk("b_data", od_b, e[63:0]);
                chk("b_tlast", 64'(ol_b), 64'(e[64]));
            end
        end
    end

    task automatic push_exp(input bit b, input logic [64:0] w);
        if (b) q_b.push_back(w);
        else   q_a.push_back(w);
    endtask

    task automatic model_pkt(input bit b, input int n, input logic [31:0] base, input bit ht,
                             input logic [63:0] tm, input logic [31:0] sid, input bit eob);
        int rem, k, seg, nw, maxs;
        logic [15:0] len;
        logic [11:0] sq;
        logic [31:0] hi, lo;
        maxs = b ? 8 : 1024;
        rem = n;
        k = 0;
        while (rem > 0) begin
            seg = (rem > maxs) ? maxs : rem;
            len = 16'(4 * seg + 8 + (ht ? 8 : 0));
            sq  = b ? seq_b : seq_a;
            push_exp(b, {1'b0, 2'b00, ht, eob & (rem == seg), sq, len, sid});
            if (b) seq_b = seq_b + 12'd1;
            else   seq_a = seq_a + 12'd1;
            if (ht) push_exp(b, {1'b0, tm});
            nw = (seg + 1) / 2;
            for (int w = 0; w < nw; w++) begin
                hi = base + 32'(k + 2 * w);
                lo = (2 * w + 1 < seg) ? base + 32'(k + 2 * w + 1) : 32'h0;
                push_exp(b, {(w == nw - 1), hi, lo});
            end
            k += seg;
            rem -= seg;
        end
    endtask

    task automatic beat(input bit b);
        int g;
        bit ok;
        g = 0;
        ok = 1'b0;
        while (!ok) begin
            #1;
            ok = b ? rdy_b : rdy_a;
            @(negedge clk);
            g++;
            if (!ok && g > 3000) begin
                chk("input_stalled", 64'(ok), 64'd1);
                return;
            end
        end
    endtask

    task automatic send_pkt(input bit b, input int n, input logic [31:0] base, input bit ht,
                            input logic [63:0] tm, input logic [31:0] sid, input bit eob);
        logic [127:0] u;
        model_pkt(b, n, base, ht, tm, sid, eob);
        u = {2'b00, ht, eob, 12'hABC, 16'hFFFF, sid, tm};
        sel = b;
        for (int i = 0; i < n; i++) begin
            i_tdata  = base + 32'(i);
            i_tuser  = (i == 0) ? u : ~u;
            i_tlast  = (i == n - 1);
            i_tvalid = 1'b1;
            beat(b);
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q_a.size() + q_b.size()) != 0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_left", 64'(q_a.size() + q_b.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; sel = 1'b0; tog_en = 1'b0; rdy_level = 1'b1;
        i_tdata = '0; i_tuser = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        seq_a = '0; seq_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_o_tvalid", 64'(ov_a), 64'd0);
        chk("rst_o_tlast", 64'(ol_a), 64'd0);
        chk("rst_o_tdata", od_a, 64'd0);
        chk("rst_i_tready", 64'(rdy_a), 64'd0);
        chk("rst_b_o_tvalid", 64'(ov_b), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_i_tready", 64'(rdy_a), 64'd1);

        send_pkt(0, 16, 32'h1, 1'b0, 64'h0, 32'h0002_0003, 1'b0);
        drain();
        send_pkt(0, 17, 32'h1, 1'b1, 64'h0123_4567_89ab_cdef, 32'h0002_0003, 1'b0);
        drain();

        tog_en = 1'b1;
        send_pkt(0, 16, 32'h100, 1'b0, 64'h0, 32'h0000_0042, 1'b0);
        send_pkt(0, 5, 32'h200, 1'b1, 64'hfeed_0000_beef_0001, 32'h0000_0043, 1'b1);
        drain();
        tog_en = 1'b0;
        rdy_level = 1'b1;

        // partial packet flushed by clear must not reappear
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_tdata = 32'hdead_0000 + 32'(i);
            i_tuser = '1;
            i_tlast = 1'b0;
            i_tvalid = 1'b1;
            beat(0);
        end
        i_tvalid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        seq_a = '0;
        for (int p = 0; p < 4097; p++) send_pkt(0, 1, 32'(p), 1'b0, 64'h0, 32'h0000_1111, 1'b0);
        drain();

        send_pkt(1, 20, 32'h300, 1'b0, 64'h0, 32'h0000_0808, 1'b1);
        send_pkt(1, 16, 32'h400, 1'b1, 64'h1111_2222_3333_4444, 32'h0000_0809, 1'b1);
        drain();

        begin
            int g;
            g = 0;
            send_pkt(0, 64, 32'h500, 1'b0, 64'h0, 32'h0000_0505, 1'b0);
            while (q_a.size() > 20 && g < 2000) begin
                @(negedge clk);
                g++;
            end
            chk("mid_body_o_tvalid", 64'(ov_a), 64'd1);
            #1 reset = 1'b0;
            #1;
            chk("async_rst_o_tvalid", 64'(ov_a), 64'd0);
            chk("async_rst_o_tdata", od_a, 64'd0);
            chk("async_rst_i_tready", 64'(rdy_a), 64'd0);
            q_a.delete();
            q_b.delete();
            seq_a = '0;
            seq_b = '0;
            @(negedge clk);
            reset = 1'b1;
            repeat (4) @(negedge clk);
            chk("post_rst_no_stale", 64'(ov_a), 64'd0);
            send_pkt(0, 2, 32'h600, 1'b0, 64'h0, 32'h0000_0606, 1'b0);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
